// File: rtl/defuzzification_if.sv
// Request/result bundle for the centroid defuzzifier: operands and strobe in,
// ready/result out. The master drives requests, the slave (the core) answers.
interface defuzzification_if #(
  parameter int unsigned pDataWidth   = 4,
  parameter int unsigned pFuzzyWidth  = 3,
  parameter int unsigned pNoOfMembers = 7
);

  logic                                  ValidIn;
  logic [pFuzzyWidth*pNoOfMembers-1:0]   Strength;
  logic [pFuzzyWidth*pNoOfMembers-1:0]   Membership;
  logic                                  Ready;
  logic                                  ValidOut;
  logic [pDataWidth-1:0]                 CrispOut;

  modport master (
    output ValidIn,
    output Strength,
    output Membership,
    input  Ready,
    input  ValidOut,
    input  CrispOut
  );

  modport slave (
    input  ValidIn,
    input  Strength,
    input  Membership,
    output Ready,
    output ValidOut,
    output CrispOut
  );

endinterface

// File: rtl/defuzzification.sv
// Centroid defuzzifier: serial multiply-accumulate over the members, then a
// restoring divide, with a fixed 18-edge latency from acceptance to the result strobe.
module defuzzification #(
  parameter int unsigned pDataWidth   = 4,
  parameter int unsigned pFuzzyWidth  = 3,
  parameter int unsigned pNoOfMembers = 7
) (
  input  logic                Clock,
  input  logic                Reset,
  defuzzification_if.slave    bus
);

  localparam int unsigned BusW     = pFuzzyWidth * pNoOfMembers;
  localparam int unsigned NumW     = pFuzzyWidth + pDataWidth + $clog2(pNoOfMembers);
  localparam int unsigned DenW     = pFuzzyWidth + $clog2(pNoOfMembers);
  localparam int unsigned CntMax   = (NumW > pNoOfMembers) ? NumW : pNoOfMembers;
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam int unsigned NegStart = (pNoOfMembers + 1) / 2;
  localparam int          SatMaxI  = (2 ** (pDataWidth - 1)) - 1;
  localparam int          SatMinI  = -(2 ** (pDataWidth - 1));

  localparam logic signed [NumW:0] SatMax = (NumW + 1)'(SatMaxI);
  localparam logic signed [NumW:0] SatMin = (NumW + 1)'(SatMinI);

  typedef enum logic [1:0] {StIdle, StAccum, StDivide, StDone} state_e;

  state_e                    r_state;
  state_e                    w_state_next;
  logic [BusW-1:0]           r_strength;
  logic [BusW-1:0]           r_membership;
  logic signed [NumW-1:0]    r_num;
  logic [DenW-1:0]           r_den;
  logic [CntW-1:0]           r_cnt;
  logic [NumW-1:0]           r_dvd;
  logic [DenW-1:0]           r_rem;
  logic                      r_neg;
  logic [pDataWidth-1:0]     r_crisp;

  logic [pFuzzyWidth-1:0]    w_s;
  logic [pFuzzyWidth-1:0]    w_m;
  logic                      w_neg_member;
  logic signed [NumW-1:0]    w_s_ext;
  logic signed [NumW-1:0]    w_m_ext;
  logic signed [NumW-1:0]    w_center;
  logic signed [NumW-1:0]    w_product;
  logic signed [NumW-1:0]    w_num_next;
  logic [DenW-1:0]           w_den_next;
  logic [NumW-1:0]           w_num_abs;
  logic                      w_accum_last;
  logic                      w_div_last;
  logic [DenW:0]             w_rem_shift;
  logic [DenW:0]             w_rem_sub;
  logic                      w_ge;
  logic [NumW-1:0]           w_q_mag;
  logic signed [NumW:0]      w_q_signed;
  logic [pDataWidth-1:0]     w_crisp;

  assign w_accum_last = (r_cnt == CntW'(pNoOfMembers - 1));
  assign w_div_last   = (r_cnt == CntW'(NumW));

  // Member select for the current accumulation step.
  always_comb begin
    w_s = '0;
    w_m = '0;
    for (int k = 0; k < int'(pNoOfMembers); k++) begin
      if (r_cnt == CntW'(k)) begin
        w_s = r_strength[k*pFuzzyWidth +: pFuzzyWidth];
        w_m = r_membership[k*pFuzzyWidth +: pFuzzyWidth];
      end
    end
  end

  always_comb begin
    w_neg_member = (r_cnt >= CntW'(NegStart));
    w_s_ext      = signed'({{(NumW - pFuzzyWidth){1'b0}}, w_s});
    w_m_ext      = signed'({{(NumW - pFuzzyWidth){1'b0}}, w_m});
    w_center     = w_neg_member ? -w_m_ext : w_m_ext;
    w_product    = w_s_ext * w_center;
    w_num_next   = r_num + w_product;
    w_den_next   = r_den + DenW'(w_s);
    w_num_abs    = w_num_next[NumW-1] ? unsigned'(-w_num_next) : unsigned'(w_num_next);
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_rem_shift = {r_rem, r_dvd[NumW-1]};
    w_ge        = (w_rem_shift >= {1'b0, r_den});
    w_rem_sub   = w_rem_shift - {1'b0, r_den};
  end

  // A zero denominator leaves all-ones in the quotient; it is discarded here.
  always_comb begin
    w_q_mag    = (r_den == '0) ? '0 : r_dvd;
    w_q_signed = r_neg ? -signed'({1'b0, w_q_mag}) : signed'({1'b0, w_q_mag});
    if (w_q_signed > SatMax) begin
      w_crisp = SatMax[pDataWidth-1:0];
    end else if (w_q_signed < SatMin) begin
      w_crisp = SatMin[pDataWidth-1:0];
    end else begin
      w_crisp = w_q_signed[pDataWidth-1:0];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (bus.ValidIn) w_state_next = StAccum;
      StAccum:  if (w_accum_last) w_state_next = StDivide;
      StDivide: if (w_div_last) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.Ready    = (r_state == StIdle);
    bus.ValidOut = (r_state == StDone);
    bus.CrispOut = r_crisp;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_strength   <= '0;
      r_membership <= '0;
      r_num        <= '0;
      r_den        <= '0;
      r_cnt        <= '0;
      r_dvd        <= '0;
      r_rem        <= '0;
      r_neg        <= 1'b0;
      r_crisp      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.ValidIn) begin
            r_strength   <= bus.Strength;
            r_membership <= bus.Membership;
            r_num        <= '0;
            r_den        <= '0;
            r_cnt        <= '0;
          end
        end
        StAccum: begin
          r_num <= w_num_next;
          r_den <= w_den_next;
          if (w_accum_last) begin
            r_cnt <= '0;
            r_dvd <= w_num_abs;
            r_neg <= w_num_next[NumW-1];
            r_rem <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDivide: begin
          if (w_div_last) begin
            // Extra cycle after the last quotient bit: sign, saturate, publish.
            r_crisp <= w_crisp;
            r_cnt   <= '0;
          end else begin
            r_rem <= w_ge ? w_rem_sub[DenW-1:0] : w_rem_shift[DenW-1:0];
            r_dvd <= {r_dvd[NumW-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/defuzzification.md
DEFUZZIFICATION -- requirements
Module: defuzzification

Interface
REQ-001 SHALL have parameter pDataWidth, default 4: crisp output width, two's complement.
REQ-002 SHALL have parameter pFuzzyWidth, default 3: per-member strength/magnitude width, unsigned.
REQ-003 SHALL have parameter pNoOfMembers, default 7: number of output fuzzy sets.
REQ-004 SHALL have port Clock  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ValidIn  input  1  request to start one defuzzification.
REQ-007 SHALL have port Strength  input  pFuzzyWidth*pNoOfMembers  firing strength per set; member k at bits [k*pFuzzyWidth+pFuzzyWidth-1 : k*pFuzzyWidth].
REQ-008 SHALL have port Membership  input  pFuzzyWidth*pNoOfMembers  center magnitude per set; same packing; k=0..6 = PL,PM,PS,Z,NS,NM,NL.
REQ-009 SHALL have port Ready  output  1  high only in IDLE.
REQ-010 SHALL have port ValidOut  output  1  one-cycle result strobe.
REQ-011 SHALL have port CrispOut  output  pDataWidth  defuzzified value, two's complement.

Function
REQ-012 SHALL interpret center_k as +magnitude for k=0..3 and -magnitude for k=4..6, sign-extended to pDataWidth.
REQ-013 SHALL compute CrispOut = trunc-toward-zero( sum(s_k*center_k) / sum(s_k) ) by centroid method.
REQ-014 SHALL use FSM states IDLE, ACCUM, DIVIDE, DONE.
REQ-015 SHALL, in IDLE with ValidIn=1, register Strength and Membership, clear accumulators and counter, go to ACCUM.
REQ-016 SHALL, in ACCUM, process exactly one member per cycle in order k=0..pNoOfMembers-1 (7 cycles), then go to DIVIDE.
REQ-017 SHALL size the numerator accumulator signed pFuzzyWidth+pDataWidth+clog2(pNoOfMembers) bits (10 at defaults) and the denominator unsigned pFuzzyWidth+clog2(pNoOfMembers) bits (6); no overflow is possible at any input.
REQ-018 SHALL, in DIVIDE, perform restoring division of |numerator| by denominator, one quotient bit per cycle, numerator-width cycles (10), then apply the numerator sign and go to DONE.
REQ-019 SHALL force the quotient to 0 when the denominator is 0, keeping the same cycle count.
REQ-020 SHALL saturate the signed quotient to the pDataWidth range before loading CrispOut.
REQ-021 SHALL update CrispOut and assert ValidOut for exactly one cycle in DONE, then return to IDLE; fixed latency: ValidOut high in the cycle after the 18th rising edge following the accepting edge.
REQ-022 SHALL hold CrispOut stable between results.
REQ-023 SHALL ignore ValidIn while Ready=0; captured operands are unaffected by input changes after acceptance.
REQ-024 SHALL not accept a new request in DONE; earliest next acceptance is the IDLE cycle after DONE.

Reset
REQ-025 SHALL, on Reset low, asynchronously force state IDLE, CrispOut=0, ValidOut=0, Ready=1, all accumulators and counters 0.
REQ-026 SHALL abandon any in-flight operation on reset, with no ValidOut for it after Reset deasserts.

Verification
REQ-027 Reset asserted mid-run -> Ready=1, ValidOut=0, CrispOut=4'b0000 immediately; released, no stale strobe.
REQ-028 Only PL: s0=7, center0=6, others 0 -> after 18 edges, ValidOut 1 cycle, CrispOut=4'b0110 (+6).
REQ-029 Z center 0 s=7, PS center 2 s=7 -> 14/14 -> CrispOut=4'b0001.
REQ-030 NM center 5 s=4, PS center 1 s=4 -> -16/8 -> CrispOut=4'b1110 (-2); NS center 7 s=1, Z s=1 -> -7/2 -> 4'b1101 (-3, truncation toward zero).
REQ-031 All strengths 0 -> CrispOut=4'b0000 at fixed latency 18.
REQ-032 ValidIn pulsed during ACCUM and DIVIDE -> ignored, exactly one ValidOut; back-to-back requests -> second accepted only after DONE.
